// File: rtl/eval_handshake_assert_monitor.sv
// eval_handshake_assert_monitor
// Watches NUM_CH valid/ready channels and flags three protocol violations per
// channel: valid dropped while stalled, payload changed while stalled, and a
// stall reaching TIMEOUT cycles. Keeps sticky per-channel error flags, a
// first-error capture and a saturating handshake counter. All outputs are
// registered.
// Optional feature macro: EVAL_HANDSHAKE_ASSERT_FATAL_EN (simulation-only
// report plus $fatal on any new error).
module eval_handshake_assert_monitor #(
    parameter int  NUM_CH  = 4,
    parameter int  DATA_W  = 32,
    parameter int  TIMEOUT = 256,
    parameter int  CNT_W   = 16,
    localparam int FCH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_chk_en,
    input  logic                     i_clear,
    input  logic [NUM_CH-1:0]        i_valid,
    input  logic [NUM_CH-1:0]        i_ready,
    input  logic [NUM_CH*DATA_W-1:0] i_payload,
    output logic [NUM_CH-1:0]        o_err_valid_hold,
    output logic [NUM_CH-1:0]        o_err_stable,
    output logic [NUM_CH-1:0]        o_err_timeout,
    output logic                     o_err_any,
    output logic [FCH_W-1:0]         o_first_ch,
    output logic [1:0]               o_first_code,
    output logic [CNT_W-1:0]         o_fire_count
);

    // Stall counter must be able to hold TIMEOUT itself (it saturates there).
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam int POP_W   = $clog2(NUM_CH + 1);
    localparam int SUM_W   = CNT_W + POP_W + 1;

    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Errors newly detected this cycle, one bit per channel.
    logic [NUM_CH-1:0] w_new_vh;
    logic [NUM_CH-1:0] w_new_st;
    logic [NUM_CH-1:0] w_new_to;
    logic [NUM_CH-1:0] w_new_ch;
    logic              w_new_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t             r_state;
            state_t             w_state_next;
            logic [STALL_W-1:0] r_stall_cnt;
            logic [STALL_W-1:0] w_stall_next;
            logic [DATA_W-1:0]  r_capture;
            logic [DATA_W-1:0]  w_capture_next;
            logic [DATA_W-1:0]  w_data;
            logic               w_vh;
            logic               w_st;
            logic               w_to;

            assign w_data = i_payload[gi*DATA_W +: DATA_W];

            // Channel state, stall length and captured payload registers.
            always_ff @(posedge i_clock or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_state     <= ST_IDLE;
                    r_stall_cnt <= '0;
                    r_capture   <= '0;
                end else begin
                    r_state     <= w_state_next;
                    r_stall_cnt <= w_stall_next;
                    r_capture   <= w_capture_next;
                end
            end

            // Channel protocol FSM: next state, stall count and error detection.
            always_comb begin
                w_state_next   = r_state;
                w_stall_next   = r_stall_cnt;
                w_capture_next = r_capture;
                w_vh           = 1'b0;
                w_st           = 1'b0;
                w_to           = 1'b0;
                if (!i_chk_en) begin
                    // Checking disabled: forget any stall, keep the capture.
                    w_state_next = ST_IDLE;
                    w_stall_next = '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (i_valid[gi] && !i_ready[gi]) begin
                                w_state_next   = ST_STALL;
                                w_stall_next   = STALL_ONE;
                                w_capture_next = w_data;
                            end else begin
                                w_stall_next = '0;
                            end
                        end
                        ST_STALL: begin
                            if (!i_valid[gi]) begin
                                w_state_next = ST_IDLE;
                                w_stall_next = '0;
                                w_vh         = 1'b1;
                            end else begin
                                w_st = (w_data != r_capture);
                                if (i_ready[gi]) begin
                                    w_state_next = ST_IDLE;
                                    w_stall_next = '0;
                                end else if (r_stall_cnt < STALL_MAX) begin
                                    // Timeout fires only on the increment
                                    // that reaches TIMEOUT, so once per stall.
                                    w_stall_next = r_stall_cnt + STALL_ONE;
                                    w_to         = (r_stall_cnt == STALL_PRE);
                                end
                            end
                        end
                        default: begin
                            w_state_next = ST_IDLE;
                            w_stall_next = '0;
                        end
                    endcase
                end
            end

            assign w_new_vh[gi] = w_vh;
            assign w_new_st[gi] = w_st;
            assign w_new_to[gi] = w_to;
        end
    endgenerate

    assign w_new_ch  = w_new_vh | w_new_st | w_new_to;
    assign w_new_any = |w_new_ch;

    // First-error candidate: lowest erroring channel, then vh > stable > timeout.
    logic [FCH_W-1:0] w_cand_ch;
    logic [1:0]       w_cand_code;

    // Pick the reporting candidate among this cycle's new errors.
    always_comb begin
        w_cand_ch   = '0;
        w_cand_code = 2'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_new_ch[c]) begin
                w_cand_ch = FCH_W'(c);
                if (w_new_vh[c]) begin
                    w_cand_code = 2'd1;
                end else if (w_new_st[c]) begin
                    w_cand_code = 2'd2;
                end else begin
                    w_cand_code = 2'd3;
                end
            end
        end
    end

    // Sticky flags and capture registers.
    logic [NUM_CH-1:0] r_err_vh;
    logic [NUM_CH-1:0] r_err_st;
    logic [NUM_CH-1:0] r_err_to;
    logic              r_err_any;
    logic [FCH_W-1:0]  r_first_ch;
    logic [1:0]        r_first_code;
    logic [CNT_W-1:0]  r_fire_count;

    logic [NUM_CH-1:0] w_err_vh_next;
    logic [NUM_CH-1:0] w_err_st_next;
    logic [NUM_CH-1:0] w_err_to_next;
    logic [FCH_W-1:0]  w_first_ch_next;
    logic [1:0]        w_first_code_next;

    // Sticky update: clear first, then new errors OR in (set wins over clear).
    always_comb begin
        w_err_vh_next     = (i_clear ? '0 : r_err_vh) | w_new_vh;
        w_err_st_next     = (i_clear ? '0 : r_err_st) | w_new_st;
        w_err_to_next     = (i_clear ? '0 : r_err_to) | w_new_to;
        w_first_ch_next   = r_first_ch;
        w_first_code_next = r_first_code;
        if (i_clear) begin
            w_first_ch_next   = '0;
            w_first_code_next = 2'd0;
        end
        if (((r_first_code == 2'd0) || i_clear) && w_new_any) begin
            w_first_ch_next   = w_cand_ch;
            w_first_code_next = w_cand_code;
        end
    end

    // Handshake popcount and saturating accumulation.
    logic [NUM_CH-1:0] w_fire;
    logic [POP_W-1:0]  w_pop;
    logic [SUM_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_fire_next;

    assign w_fire = i_valid & i_ready & {NUM_CH{i_chk_en}};

    // Count handshakes this cycle and saturate the running total.
    always_comb begin
        w_pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pop = w_pop + POP_W'(w_fire[c]);
        end
        w_sum = SUM_W'(r_fire_count) + SUM_W'(w_pop);
        if (w_sum > SUM_W'({CNT_W{1'b1}})) begin
            w_fire_next = {CNT_W{1'b1}};
        end else begin
            w_fire_next = w_sum[CNT_W-1:0];
        end
    end

    // Output-side registers: sticky flags, summary, first-error capture, counter.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_err_vh     <= '0;
            r_err_st     <= '0;
            r_err_to     <= '0;
            r_err_any    <= 1'b0;
            r_first_ch   <= '0;
            r_first_code <= 2'd0;
            r_fire_count <= '0;
        end else begin
            r_err_vh     <= w_err_vh_next;
            r_err_st     <= w_err_st_next;
            r_err_to     <= w_err_to_next;
            r_err_any    <= |{w_err_vh_next, w_err_st_next, w_err_to_next};
            r_first_ch   <= w_first_ch_next;
            r_first_code <= w_first_code_next;
            r_fire_count <= w_fire_next;
        end
    end

    assign o_err_valid_hold = r_err_vh;
    assign o_err_stable     = r_err_st;
    assign o_err_timeout    = r_err_to;
    assign o_err_any        = r_err_any;
    assign o_first_ch       = r_first_ch;
    assign o_first_code     = r_first_code;
    assign o_fire_count     = r_fire_count;

`ifdef EVAL_HANDSHAKE_ASSERT_FATAL_EN
`ifndef SYNTHESIS
    // Simulation-only: report the first new error of the cycle and stop.
    always @(posedge i_clock) begin
        if (i_reset_n && w_new_any) begin
            $display("eval_handshake_assert_monitor: channel %0d error code %0d",
                     w_cand_ch, w_cand_code);
            $fatal(1, "eval_handshake_assert_monitor: protocol error");
        end
    end
`endif
`else
    // Without the fatal path the monitor reports only through its outputs.
`endif

endmodule

// File: tb/tb_eval_handshake_assert_monitor.sv
// Self-checking bench for eval_handshake_assert_monitor: directed scenarios
// followed by randomized traffic compared against a behavioural model.
module tb_eval_handshake_assert_monitor;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int FCW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              chk_en = 1'b1;
    logic              clear = 1'b0;
    logic [NCH-1:0]    valid = '0;
    logic [NCH-1:0]    ready = '0;
    logic [NCH*DW-1:0] payload = '0;

    logic [NCH-1:0]    err_vh;
    logic [NCH-1:0]    err_st;
    logic [NCH-1:0]    err_to;
    logic              err_any;
    logic [FCW-1:0]    first_ch;
    logic [1:0]        first_code;
    logic [CW-1:0]     fire_count;

    eval_handshake_assert_monitor #(
        .NUM_CH (NCH),
        .DATA_W (DW),
        .TIMEOUT(TO),
        .CNT_W  (CW)
    ) u_dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_chk_en        (chk_en),
        .i_clear         (clear),
        .i_valid         (valid),
        .i_ready         (ready),
        .i_payload       (payload),
        .o_err_valid_hold(err_vh),
        .o_err_stable    (err_st),
        .o_err_timeout   (err_to),
        .o_err_any       (err_any),
        .o_first_ch      (first_ch),
        .o_first_code    (first_code),
        .o_fire_count    (fire_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit verbose  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    bit          m_stalled [NCH];
    int          m_len     [NCH];
    logic [31:0] m_cap     [NCH];
    logic [3:0]  m_vh, m_st, m_to;
    logic        m_any;
    int          m_fch, m_fcode, m_fire;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_stalled[c] = 0; m_len[c] = 0; m_cap[c] = '0;
        end
        m_vh = '0; m_st = '0; m_to = '0; m_any = 0;
        m_fch = 0; m_fcode = 0; m_fire = 0;
    endtask

    task automatic model_step();
        logic [3:0] nv, ns, nt;
        logic [31:0] d;
        nv = '0; ns = '0; nt = '0;
        for (int c = 0; c < NCH; c++) begin
            d = payload[c*DW +: DW];
            if (!chk_en) begin
                m_stalled[c] = 0; m_len[c] = 0;
            end else if (!m_stalled[c]) begin
                if (valid[c] && !ready[c]) begin
                    m_stalled[c] = 1; m_len[c] = 1; m_cap[c] = d;
                end
            end else if (!valid[c]) begin
                nv[c] = 1; m_stalled[c] = 0; m_len[c] = 0;
            end else begin
                if (d != m_cap[c]) ns[c] = 1;
                if (ready[c]) begin
                    m_stalled[c] = 0; m_len[c] = 0;
                end else if (m_len[c] < TO) begin
                    m_len[c]++;
                    if (m_len[c] == TO) nt[c] = 1;
                end
            end
        end
        if (chk_en) begin
            m_fire = m_fire + $countones(valid & ready);
            if (m_fire > CNT_MAX) m_fire = CNT_MAX;
        end
        if (clear) begin
            m_vh = '0; m_st = '0; m_to = '0; m_fch = 0; m_fcode = 0;
        end
        if ((m_fcode == 0 || clear) && (nv | ns | nt) != 0) begin
            for (int c = 0; c < NCH; c++) begin
                if (nv[c] | ns[c] | nt[c]) begin
                    m_fch = c;
                    m_fcode = nv[c] ? 1 : (ns[c] ? 2 : 3);
                    break;
                end
            end
        end
        m_vh |= nv; m_st |= ns; m_to |= nt;
        m_any = |{m_vh, m_st, m_to};
    endtask

    task automatic compare_all();
        check_eq("err_valid_hold", err_vh, m_vh);
        check_eq("err_stable", err_st, m_st);
        check_eq("err_timeout", err_to, m_to);
        check_eq("err_any", err_any, m_any);
        check_eq("first_ch", first_ch, m_fch);
        check_eq("first_code", first_code, m_fcode);
        check_eq("fire_count", fire_count, m_fire);
    endtask

    // One clock: DUT and model consume the same inputs, outputs sampled #1 later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (verbose)
            $display("txn t=%0t v=%b r=%b en=%b clr=%b -> vh=%b st=%b to=%b any=%b fch=%0d fcode=%0d fire=%0d",
                     $time, valid, ready, chk_en, clear, err_vh, err_st, err_to, err_any,
                     first_ch, first_code, fire_count);
    endtask

    task automatic set_pl(input int c, input logic [31:0] v);
        payload[c*DW +: DW] = v;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must be zero immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("reset_outputs", {err_vh, err_st, err_to, err_any, first_ch, first_code, fire_count}, '0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        valid = '0; ready = '0; clear = 1'b0; chk_en = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ready_bias;
        verbose = 1'b1;
        #1;
        do_reset();

        // Legal stall of ch1 with held payload, then fire.
        valid = 4'b0010; set_pl(1, 32'hA5A5A5A5);
        repeat (3) step();
        ready = 4'b0010;
        step();
        idle_inputs();
        step();
        check_eq("t1_err_any", err_any, 1'b0);
        check_eq("t1_fire_count", fire_count, 4'd1);
        check_eq("t1_first_code", first_code, 2'd0);

        // ch2 drops valid after two stalled cycles.
        valid = 4'b0100;
        repeat (2) step();
        valid = 4'b0000;
        step();
        check_eq("t2_err_vh", err_vh, 4'b0100);
        check_eq("t2_first_ch", first_ch, 2'd2);
        check_eq("t2_first_code", first_code, 2'd1);
        check_eq("t2_err_any", err_any, 1'b1);

        // ch0 payload changes during stall; flag sticks after change back.
        do_reset();
        valid = 4'b0001; set_pl(0, 32'h1);
        step();
        set_pl(0, 32'h2);
        step();
        check_eq("t3_err_st", err_st, 4'b0001);
        check_eq("t3_first_code", first_code, 2'd2);
        set_pl(0, 32'h1);
        step();
        ready = 4'b0001;
        step();
        idle_inputs();
        step();
        check_eq("t3_err_st_sticky", err_st, 4'b0001);

        // ch3 stalls 20 cycles: timeout on the 8th stalled cycle only.
        do_reset();
        valid = 4'b1000; set_pl(3, 32'h33);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == TO - 1) check_eq("t4_to_before", err_to, 4'b0000);
            if (k == TO) check_eq("t4_to_at", err_to, 4'b1000);
            if (k == TO) check_eq("t4_code_at", first_code, 2'd3);
        end
        check_eq("t4_to_held", err_to, 4'b1000);
        ready = 4'b1000;
        step();

        // ch3 and ch1 erroring together: lowest channel captured.
        do_reset();
        idle_inputs();
        valid = 4'b1010;
        step();
        valid = 4'b0000;
        step();
        check_eq("t4_dual_vh", err_vh, 4'b1010);
        check_eq("t4_dual_first_ch", first_ch, 2'd1);

        // clear coincides with a new ch0 valid_hold error: set wins.
        valid = 4'b0001;
        step();
        valid = 4'b0000; clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("t5_err_vh", err_vh, 4'b0001);
        check_eq("t5_first_ch", first_ch, 2'd0);
        check_eq("t5_first_code", first_code, 2'd1);
        check_eq("t5_err_any", err_any, 1'b1);

        // All channels fire five cycles: counter saturates at 15.
        do_reset();
        valid = 4'hF; ready = 4'hF;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq("t6_fire_count", fire_count, (4 * k > CNT_MAX) ? CNT_MAX : 4 * k);
        end
        idle_inputs();

        // Reset mid-stall, then release with valid low: no error.
        valid = 4'b0100;
        repeat (3) step();
        do_reset();
        valid = 4'b0000;
        step();
        check_eq("t7_no_err_after_reset", err_any, 1'b0);

        // Randomized traffic against the model.
        verbose = 1'b0;
        ready_bias = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 249) begin
                do_reset();
                ready_bias = 4'($urandom_range(0, 15));
            end
            chk_en = ($urandom_range(0, 19) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            for (int c = 0; c < NCH; c++) begin
                valid[c] = ($urandom_range(0, 7) != 0);
                ready[c] = ready_bias[c] ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 11) == 0) set_pl(c, 32'($urandom_range(0, 3)));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
